// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD update path: controller state encoding and the
// default displayed-value width, also used by the display stage.
package lcd_pkg;

  localparam int DATA_W_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } lcd_state_t;

endpackage

// File: rtl/lcd_holdoff_timer.sv
// Saturating down-counter that enforces the minimum spacing between the starts
// of successive LCD update requests; Ready is high once the count reaches zero.
module lcd_holdoff_timer
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 5000000,
  parameter int CNT_W          = 23
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Load,
  output logic Ready
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Ready = (cnt_q == '0);

endmodule

// File: rtl/lcd_update_ctrl.sv
// Captures the two processor-written values and paces four-phase update
// requests to the LCD display stage. Define LCD_CHANGE_FILTER_EN to ignore
// writes that do not change a value.
//   state  | meaning
//   S_IDLE | no request outstanding; start one when Dirty and holdoff Ready
//   S_REQ  | LCDUpdate high, data frozen, waiting for LCDAck
//   S_REL  | LCDUpdate low, waiting for LCDAck to drop
module lcd_update_ctrl
  import lcd_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REFRESH_CYCLES = 5000000,
  parameter int CNT_W          = 23
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Val0,
  input  logic              Val0Wr,
  input  logic [DATA_W-1:0] Val1,
  input  logic              Val1Wr,
  output logic [DATA_W-1:0] DataOut_X,
  output logic [DATA_W-1:0] DataOut_Y,
  output logic              LCDUpdate,
  input  logic              LCDAck,
  output logic              Busy
);

  lcd_state_t        state_q, state_d;
  logic [DATA_W-1:0] shadow0_q, shadow0_d;
  logic [DATA_W-1:0] shadow1_q, shadow1_d;
  logic [DATA_W-1:0] data_x_q, data_x_d;
  logic [DATA_W-1:0] data_y_q, data_y_d;
  logic              update_q, update_d;
  logic              busy_q, busy_d;
  logic              dirty_q, dirty_d;
  logic              set0, set1;
  logic              load;
  logic              ready;

  lcd_holdoff_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .CNT_W          (CNT_W)
  ) u_holdoff (
    .Clk   (Clk),
    .Rst   (Rst),
    .Load  (load),
    .Ready (ready)
  );

`ifdef LCD_CHANGE_FILTER_EN
  assign set0 = Val0Wr && (Val0 != shadow0_q);
  assign set1 = Val1Wr && (Val1 != shadow1_q);
`else
  assign set0 = Val0Wr;
  assign set1 = Val1Wr;
`endif

  always_comb begin
    state_d   = state_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    data_x_d  = data_x_q;
    data_y_d  = data_y_q;
    update_d  = update_q;
    dirty_d   = dirty_q;
    load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dirty_q && ready) begin
          data_x_d = shadow0_q;
          data_y_d = shadow1_q;
          update_d = 1'b1;
          dirty_d  = 1'b0;
          load     = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (LCDAck) begin
          update_d = 1'b0;
          state_d  = S_REL;
        end
      end
      S_REL: begin
        if (!LCDAck) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        update_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Capture runs in every state; a same-edge write wins over the clear above.
    if (Val0Wr) shadow0_d = Val0;
    if (Val1Wr) shadow1_d = Val1;
    if (set0 || set1) dirty_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      shadow0_q <= '0;
      shadow1_q <= '0;
      data_x_q  <= '0;
      data_y_q  <= '0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      dirty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      data_x_q  <= data_x_d;
      data_y_q  <= data_y_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      dirty_q   <= dirty_d;
    end
  end

  assign DataOut_X = data_x_q;
  assign DataOut_Y = data_y_q;
  assign LCDUpdate = update_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_lcd_update_ctrl.sv
// Bench for lcd_update_ctrl: directed handshake scenarios plus random writes,
// checked every cycle against a request-level reference model.
module tb_lcd_update_ctrl;

  localparam int DW = 10;
  localparam int R  = 8;
`ifdef LCD_CHANGE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [DW-1:0] Val0 = '0, Val1 = '0;
  logic          Val0Wr = 1'b0, Val1Wr = 1'b0;
  logic [DW-1:0] DataOut_X, DataOut_Y;
  logic          LCDUpdate, Busy;
  logic          LCDAck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_update_ctrl #(.DATA_W(DW), .REFRESH_CYCLES(R), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .Val0(Val0), .Val0Wr(Val0Wr), .Val1(Val1), .Val1Wr(Val1Wr),
    .DataOut_X(DataOut_X), .DataOut_Y(DataOut_Y), .LCDUpdate(LCDUpdate),
    .LCDAck(LCDAck), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: request starts when nothing is outstanding, something new
  // was written, and at least R edges passed since the previous start.
  int          m_edge, m_last, m_phase;
  logic [DW-1:0] m_sh0, m_sh1;
  bit          m_dirty;
  logic [DW-1:0] exp_x, exp_y;
  bit          exp_upd, exp_busy;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_edge = 0; m_last = -R; m_phase = 0;
      m_sh0 = '0; m_sh1 = '0; m_dirty = 1'b1;
      exp_x = '0; exp_y = '0; exp_upd = 1'b0; exp_busy = 1'b0;
    end else begin
      m_edge++;
      if (m_phase == 0 && m_dirty && (m_edge - m_last >= R)) begin
        exp_x = m_sh0; exp_y = m_sh1; exp_upd = 1'b1;
        m_dirty = 1'b0; m_last = m_edge; m_phase = 1;
      end else if (m_phase == 1 && LCDAck) begin
        exp_upd = 1'b0; m_phase = 2;
      end else if (m_phase == 2 && !LCDAck) begin
        m_phase = 0;
      end
      if (Val0Wr) begin
        if (!FILTER || Val0 != m_sh0) m_dirty = 1'b1;
        m_sh0 = Val0;
      end
      if (Val1Wr) begin
        if (!FILTER || Val1 != m_sh1) m_dirty = 1'b1;
        m_sh1 = Val1;
      end
      exp_busy = (m_phase != 0);
    end
  end

  // Display-stage responder: ack two cycles into a request, release one cycle after it drops.
  int ack_cnt = 0;
  always @(negedge Clk) begin
    if (Rst) begin
      LCDAck = 1'b0; ack_cnt = 0;
    end else if (LCDUpdate && !LCDAck) begin
      ack_cnt++;
      if (ack_cnt >= 2) begin
        LCDAck = 1'b1; ack_cnt = 0;
      end
    end else if (!LCDUpdate && LCDAck) begin
      LCDAck = 1'b0;
    end
  end

  bit chk_en = 1'b0;
  int neg_cnt = 0, rise_cnt = 0, last_rise = 0;
  bit prev_upd = 1'b0;
  always @(negedge Clk) begin
    neg_cnt++;
    if (LCDUpdate && !prev_upd) begin
      rise_cnt++; last_rise = neg_cnt;
    end
    prev_upd = LCDUpdate;
    if (chk_en) begin
      chk("cyc_upd",  32'(LCDUpdate), 32'(exp_upd));
      chk("cyc_x",    32'(DataOut_X), 32'(exp_x));
      chk("cyc_y",    32'(DataOut_Y), 32'(exp_y));
      chk("cyc_busy", 32'(Busy),      32'(exp_busy));
    end
  end

  task automatic tick();
    @(negedge Clk); #1;
  endtask

  task automatic wait_rise(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge Clk);
      if (LCDUpdate) begin ok = 1'b1; break; end
    end
    #1;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge Clk);
      if (!Busy && !LCDUpdate && !LCDAck) begin ok = 1'b1; break; end
    end
    #1;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wr0(input logic [DW-1:0] v);
    Val0 = v; Val0Wr = 1'b1; tick(); Val0Wr = 1'b0;
  endtask

  initial begin
    int r0, r1;
    #2 Rst = 1'b1;
    tick();
    chk("rst_upd",  32'(LCDUpdate), 32'd0);
    chk("rst_x",    32'(DataOut_X), 32'd0);
    chk("rst_y",    32'(DataOut_Y), 32'd0);
    chk("rst_busy", 32'(Busy),      32'd0);
    chk_en = 1'b1;
    Rst = 1'b0;

    // Power-up update of 0/0 without any write, then silence.
    wait_rise("t1_rise", 3);
    chk("t1_x", 32'(DataOut_X), 32'd0);
    chk("t1_y", 32'(DataOut_Y), 32'd0);
    wait_idle("t1_idle", 20);
    chk("t1_busy", 32'(Busy), 32'd0);
    r0 = rise_cnt;
    repeat (12) tick();
    chk("t1_no_more", 32'(rise_cnt), 32'(r0));

    // Single write, exact two-cycle latency.
    Val0 = 10'd123; Val0Wr = 1'b1;
    @(negedge Clk);
    chk("t2_not_yet", 32'(LCDUpdate), 32'd0);
    #1 Val0Wr = 1'b0;
    @(negedge Clk);
    chk("t2_upd", 32'(LCDUpdate), 32'd1);
    chk("t2_x",   32'(DataOut_X), 32'd123);
    #1;
    wait_idle("t2_idle", 20);
    repeat (10) tick();

    // Burst to Val1 during a handshake coalesces into one holdoff-limited request.
    wr0(10'd200);
    wait_rise("t3_rise_a", 4);
    r0 = last_rise; r1 = rise_cnt;
    Val1Wr = 1'b1;
    Val1 = 10'd5; tick();
    Val1 = 10'd6; tick();
    Val1 = 10'd7; tick();
    Val1Wr = 1'b0;
    wait_idle("t3_idle_a", 20);
    wait_rise("t3_rise_b", 20);
    chk("t3_y", 32'(DataOut_Y), 32'd7);
    chk("t3_x", 32'(DataOut_X), 32'd200);
    chk("t3_gap_ge_R", 32'(last_rise - r0 >= R), 32'd1);
    chk("t3_one_req", 32'(rise_cnt - r1), 32'd1);
    wait_idle("t3_idle_b", 20);
    r0 = rise_cnt;
    repeat (12) tick();
    chk("t3_no_more", 32'(rise_cnt), 32'(r0));

    // Async reset mid-request, then a write on the very first (start) edge.
    Val1 = 10'd9; Val1Wr = 1'b1; tick(); Val1Wr = 1'b0;
    wait_rise("t4_rise", 4);
    #1 Rst = 1'b1;
    #1;
    chk("t4_rst_upd",  32'(LCDUpdate), 32'd0);
    chk("t4_rst_x",    32'(DataOut_X), 32'd0);
    chk("t4_rst_y",    32'(DataOut_Y), 32'd0);
    chk("t4_rst_busy", 32'(Busy),      32'd0);
    tick(); tick();
    Rst = 1'b0; Val0 = 10'd55; Val0Wr = 1'b1;
    tick(); Val0Wr = 1'b0;
    chk("t4_upd0", 32'(LCDUpdate), 32'd1);
    chk("t4_x0",   32'(DataOut_X), 32'd0);
    chk("t4_y0",   32'(DataOut_Y), 32'd0);
    wait_idle("t4_idle0", 20);
    wait_rise("t4_rise1", 20);
    chk("t4_x1", 32'(DataOut_X), 32'd55);
    wait_idle("t4_idle1", 20);
    repeat (10) tick();

    // Rewriting an identical value: traffic only without the change filter.
    wr0(10'd123);
    wait_rise("t5_rise", 4);
    wait_idle("t5_idle", 20);
    repeat (10) tick();
    r0 = rise_cnt;
    wr0(10'd123);
    repeat (14) tick();
    chk("t5_same_val_reqs", 32'(rise_cnt - r0), FILTER ? 32'd0 : 32'd1);
    wait_idle("t5_idle2", 20);

    // Random writes with small value range (hits equal rewrites) and rare resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        Rst = 1'b1; tick(); tick(); Rst = 1'b0;
      end
      Val0Wr = ($urandom_range(0, 5) == 0);
      Val1Wr = ($urandom_range(0, 5) == 0);
      Val0 = DW'($urandom_range(0, 3));
      Val1 = DW'($urandom_range(0, 3));
      tick();
    end
    Val0Wr = 1'b0; Val1Wr = 1'b0;
    repeat (30) tick();
    wait_idle("end_idle", 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
